// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: segment codes (active-low
// {dp,g,f,e,d,c,b,a}), digit positions and the digit index type.
package seven_segment_scanner_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t DIG_SEC0 = 2'd0;
   localparam digit_idx_t DIG_SEC1 = 2'd1;
   localparam digit_idx_t DIG_MIN0 = 2'd2;
   localparam digit_idx_t DIG_MIN1 = 2'd3;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bcd_to_segment.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes are blank.
module bcd_to_segment
   import seven_segment_scanner_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame digit
// snapshot and adjust-mode blinking of the selected digit pair.
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 100000,
   parameter int unsigned BLINK_DIV     = 25000000,
   parameter bit          DP_ON_MINUTE0 = 1'b1
) (
   input  logic       in_clock,
   input  logic       in_reset,
   input  logic [3:0] in_minute1,
   input  logic [3:0] in_minute0,
   input  logic [3:0] in_second1,
   input  logic [3:0] in_second0,
   input  logic       in_adjust,
   input  logic       in_select,
   output logic [3:0] out_anode,
   output logic [7:0] out_seven_segment
);

   localparam int unsigned ScanW  = $clog2(SCAN_DIV);
   localparam int unsigned BlinkW = $clog2(BLINK_DIV);

   logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              phase_q, phase_d;
   digit_idx_t        idx_q, idx_d;
   logic [3:0][3:0]   snap_q, snap_d;
   logic [3:0]        anode_q, anode_d;
   logic [7:0]        seg_q, seg_d;

   logic [3:0] cur_digit;
   logic [7:0] dec_seg;
   logic       blank;

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         idx_q       <= DIG_SEC0;
         snap_q      <= '0;
         anode_q     <= 4'hF;
         seg_q       <= SEG_BLANK;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      snap_d     = snap_q;
      if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         idx_d      = digit_idx_t'(idx_q + 2'd1);
         // Capture a coherent frame only as the last digit hands over to the first.
         if (idx_q == DIG_MIN1) begin
            snap_d = {in_minute1, in_minute0, in_second1, in_second0};
         end
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   assign cur_digit = snap_q[idx_q];

   bcd_to_segment u_decoder (
      .digit_i (cur_digit),
      .seg_o   (dec_seg)
   );

   always_comb begin
      blank = 1'b0;
      if (in_adjust && phase_q) begin
         if (in_select) begin
            blank = (idx_q == DIG_SEC0) || (idx_q == DIG_SEC1);
         end else begin
            blank = (idx_q == DIG_MIN0) || (idx_q == DIG_MIN1);
         end
      end
   end

   always_comb begin
      anode_d = ~(4'b0001 << idx_q);
      seg_d   = dec_seg;
      if (blank) begin
         seg_d = SEG_BLANK;
      end else if (DP_ON_MINUTE0 && (idx_q == DIG_MIN0)) begin
         seg_d[7] = 1'b0;
      end
   end

   assign out_anode         = anode_q;
   assign out_seven_segment = seg_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a cycle-count model.
module tb_seven_segment_scanner;

   localparam int S = 4;
   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] m1 = 4'd0, m0 = 4'd0, s1 = 4'd0, s0 = 4'd0;
   logic       adj = 1'b0, sel = 1'b0;
   logic [3:0] anode;
   logic [7:0] seg;

   seven_segment_scanner #(
      .SCAN_DIV      (S),
      .BLINK_DIV     (B),
      .DP_ON_MINUTE0 (1'b1)
   ) dut (
      .in_clock          (clk),
      .in_reset          (rst),
      .in_minute1        (m1),
      .in_minute0        (m0),
      .in_second1        (s1),
      .in_second0        (s0),
      .in_adjust         (adj),
      .in_select         (sel),
      .out_anode         (anode),
      .out_seven_segment (seg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: k counts edges since reset release; index, phase and frame
   // boundaries all follow from k by division.
   int          mk;
   logic [15:0] msnap;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg;
   bit          mvalid = 1'b0;

   // Literal expectations posted by the stimulus process.
   bit          lit_valid = 1'b0;
   string       lit_name;
   logic [3:0]  lit_an;
   logic [7:0]  lit_seg;

   function automatic logic [7:0] decode(input logic [3:0] d);
      logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      if (d < 4'd10) return tbl[d];
      return 8'hFF;
   endfunction

   function automatic logic [7:0] model_seg(input int k, input logic [15:0] snap,
                                            input logic a, input logic sl);
      int         idx = (k / S) % 4;
      int         ph  = (k / B) % 2;
      logic [7:0] v;
      if (a && ph == 1 && (sl ? (idx < 2) : (idx >= 2))) return 8'hFF;
      v = decode(snap[idx*4 +: 4]);
      if (idx == 2) v[7] = 1'b0;
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mk      <= 0;
         msnap   <= '0;
         exp_an  <= 4'hF;
         exp_seg <= 8'hFF;
         mvalid  <= 1'b1;
      end else begin
         exp_an  <= ~(4'b0001 << ((mk / S) % 4));
         exp_seg <= model_seg(mk, msnap, adj, sel);
         if (mk % (4 * S) == 4 * S - 1) msnap <= {m1, m0, s1, s0};
         mk <= mk + 1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         checks++;
         if (anode !== exp_an || seg !== exp_seg) begin
            errors++;
            $display("FAIL model k=%0d: anode/seg got %b/%h want %b/%h",
                     mk, anode, seg, exp_an, exp_seg);
         end
      end
      if (lit_valid) begin
         checks++;
         if (anode !== lit_an || seg !== lit_seg) begin
            errors++;
            $display("FAIL %s: anode/seg got %b/%h want %b/%h",
                     lit_name, anode, seg, lit_an, lit_seg);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [3:0] an, input logic [7:0] sg);
      lit_name  = name;
      lit_an    = an;
      lit_seg   = sg;
      lit_valid = 1'b1;
      @(negedge clk);
      #1;
      lit_valid = 1'b0;
   endtask

   initial begin
      tick(1);
      lit("reset_held", 4'b1111, 8'hFF);
      tick(2);
      rst = 1'b0;
      m1 = 4'd1; m0 = 4'd2; s1 = 4'd3; s0 = 4'd4;
      tick(1);   // k=0
      lit("first_digit", 4'b1110, 8'hC0);
      tick(8);   // k=8
      lit("dp_zero_frame", 4'b1011, 8'h40);
      tick(16);  // k=24
      lit("min0_digit2", 4'b1011, 8'h24);
      tick(8);   // k=32
      lit("sec0_digit4", 4'b1110, 8'h99);
      tick(4);   // k=36, index 1
      s0 = 4'd7;
      tick(12);  // k=48
      lit("sec0_after_wrap", 4'b1110, 8'hF8);
      adj = 1'b1; sel = 1'b1;
      tick(4);   // k=52
      lit("blink_sec1", 4'b1101, 8'hFF);
      tick(4);   // k=56
      lit("no_blink_min0", 4'b1011, 8'h24);
      sel = 1'b0;
      tick(4);   // k=60
      lit("blink_min1", 4'b0111, 8'hFF);
      tick(4);   // k=64
      lit("phase0_sec0", 4'b1110, 8'hF8);
      adj = 1'b0;
      s0  = 4'hA;
      tick(16);  // k=80
      lit("non_bcd_blank", 4'b1110, 8'hFF);
      adj = 1'b1; sel = 1'b1;
      tick(8);   // k=88, index 2, phase 1
      rst = 1'b1;
      tick(1);
      lit("reset_midframe", 4'b1111, 8'hFF);
      rst = 1'b0;
      adj = 1'b0;
      tick(1);
      lit("restart_zero", 4'b1110, 8'hC0);

      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if ($urandom_range(0, 9) == 0) m1 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) m0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) s1 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) s0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) adj = ~adj;
         if ($urandom_range(0, 29) == 0) sel = ~sel;
         rst = ($urandom_range(0, 599) == 0);
      end
      rst = 1'b0;
      tick(2);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
